// File: rtl/sumador_registrado_if.sv
// -----------------------------------------------------------------------------
// sumador_registrado_if
// Bundle of operand/result signals for the registered adder.
//   enb   : capture enable (driver -> adder)
//   a, b  : unsigned operands, WIDTH bits (driver -> adder)
//   c     : registered sum, WIDTH bits (adder -> driver)
//   carry : registered unsigned carry-out
//   ovf   : registered two's-complement overflow
//   valid : one-cycle strobe following each enabled edge
// Modports: master = stimulus side, slave = adder side.
// -----------------------------------------------------------------------------
interface sumador_registrado_if #(
    parameter int WIDTH = 4
);
    logic             enb;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             carry;
    logic             ovf;
    logic             valid;

    modport master (
        output enb, a, b,
        input  c, carry, ovf, valid
    );

    modport slave (
        input  enb, a, b,
        output c, carry, ovf, valid
    );
endinterface

// File: rtl/sumador_registrado.sv
// -----------------------------------------------------------------------------
// sumador_registrado
// Registered unsigned adder with carry-out, signed overflow and valid strobe.
// On a rising clk edge with enb=1 the sum a+b is captured into c; with enb=0
// c/carry/ovf hold. valid follows enb by one edge. All outputs come straight
// from flops, so there is no combinational input-to-output path.
//
// Ports:
//   clk      : system clock, rising edge active
//   reset_L  : asynchronous active-low reset, clears all outputs at once
//   bus      : sumador_registrado_if.slave (enb, a, b in; c, carry, ovf, valid out)
//
// Parameters:
//   WIDTH    : operand/sum width in bits (>= 2)
//   SATURATE : 0 = wrap modulo 2^WIDTH, 1 = clamp c to all-ones on carry-out
// -----------------------------------------------------------------------------
module sumador_registrado #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_L,
    sumador_registrado_if.slave   bus
);

    localparam int MSB = WIDTH - 1;

    // Full-width sum; bit WIDTH is the unsigned carry-out.
    logic [WIDTH:0]   sum_w;

    logic [WIDTH-1:0] c_q,     c_d;
    logic             carry_q, carry_d;
    logic             ovf_q,   ovf_d;
    logic             valid_q, valid_d;

    assign sum_w = {1'b0, bus.a} + {1'b0, bus.b};

    always_comb begin
        c_d     = c_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        valid_d = bus.enb;
        if (bus.enb) begin
            // carry/ovf always describe the true sum, even when c is clamped.
            carry_d = sum_w[WIDTH];
            ovf_d   = (bus.a[MSB] == bus.b[MSB]) && (sum_w[MSB] != bus.a[MSB]);
            if (SATURATE && sum_w[WIDTH]) begin
                c_d = '1;
            end else begin
                c_d = sum_w[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            c_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            c_q     <= c_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign bus.c     = c_q;
    assign bus.carry = carry_q;
    assign bus.ovf   = ovf_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_sumador_registrado.sv
// -----------------------------------------------------------------------------
// tb_sumador_registrado
// Drives a wrapping (SATURATE=0) and a clamping (SATURATE=1) adder with the
// same directed vectors. Each enabled vector pushes its hand-computed result
// into a scoreboard queue; a monitor pops and compares whenever valid is seen.
// Reset, latency, hold and mid-run reset behaviour are checked directly.
// -----------------------------------------------------------------------------
module tb_sumador_registrado;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] c_wrap;
        logic [W-1:0] c_sat;
        logic         carry;
        logic         ovf;
    } exp_t;

    logic clk;
    logic reset_L;

    sumador_registrado_if #(.WIDTH(W)) if0 ();
    sumador_registrado_if #(.WIDTH(W)) if1 ();

    sumador_registrado #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (if0)
    );

    sumador_registrado #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge, away from the capturing edge.
    task automatic drive(input logic en, input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        if0.enb = en; if0.a = va; if0.b = vb;
        if1.enb = en; if1.a = va; if1.b = vb;
    endtask

    task automatic push(input logic [W-1:0] cw, input logic [W-1:0] cs,
                        input logic cy, input logic ov);
        exp_t e;
        e.c_wrap = cw; e.c_sat = cs; e.carry = cy; e.ovf = ov;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] cw, input logic [W-1:0] cs,
                         input logic cy, input logic ov);
        drive(1'b1, va, vb);
        push(cw, cs, cy, ov);
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_c_wrap"},  32'(if0.c),     32'h0);
        chk({nm, "_c_sat"},   32'(if1.c),     32'h0);
        chk({nm, "_carry"},   32'(if0.carry), 32'h0);
        chk({nm, "_ovf"},     32'(if0.ovf),   32'h0);
        chk({nm, "_valid"},   32'(if0.valid), 32'h0);
        chk({nm, "_valid_s"}, 32'(if1.valid), 32'h0);
    endtask

    // Monitor: compare outputs against the scoreboard whenever valid is high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if0.valid !== if1.valid) begin
                n_cmp++; n_bad++;
                $display("FAIL valid_pair: wrap %b sat %b", if0.valid, if1.valid);
            end
            if (if0.valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_valid: c=%0h with empty scoreboard", if0.c);
                end else begin
                    e = sb.pop_front();
                    chk("mon_c_wrap", 32'(if0.c),     32'(e.c_wrap));
                    chk("mon_c_sat",  32'(if1.c),     32'(e.c_sat));
                    chk("mon_carry",  32'(if0.carry), 32'(e.carry));
                    chk("mon_carry_s",32'(if1.carry), 32'(e.carry));
                    chk("mon_ovf",    32'(if0.ovf),   32'(e.ovf));
                    chk("mon_ovf_s",  32'(if1.ovf),   32'(e.ovf));
                end
            end
        end
    end

    initial begin
        int waited;

        // Reset held while clocking with enb=1: outputs must stay clear.
        reset_L = 1'b0;
        if0.enb = 1'b1; if0.a = 4'h5; if0.b = 4'h3;
        if1.enb = 1'b1; if1.a = 4'h5; if1.b = 4'h3;
        repeat (3) begin
            @(negedge clk);
            #1 chk_cleared("reset_hold");
        end

        // Release: very first edge is a normal capture of 5+3.
        @(negedge clk);
        reset_L = 1'b1;
        push(4'h8, 4'h8, 1'b0, 1'b1);

        // Basic add; c must not move before the capturing edge.
        issue(4'h3, 4'h4, 4'h7, 4'h7, 1'b0, 1'b0);
        #1 chk("latency_not_before", 32'(if0.c), 32'h8);

        issue(4'hF, 4'h1, 4'h0, 4'hF, 1'b1, 1'b0);   // wrap vs clamp
        issue(4'h7, 4'h1, 4'h8, 4'h8, 1'b0, 1'b1);   // signed overflow only
        issue(4'hC, 4'h9, 4'h5, 4'hF, 1'b1, 1'b1);   // carry and overflow
        issue(4'h2, 4'h3, 4'h5, 4'h5, 1'b0, 1'b0);
        issue(4'h8, 4'h8, 4'h0, 4'hF, 1'b1, 1'b1);   // -8 + -8
        issue(4'hF, 4'hF, 4'hE, 4'hF, 1'b1, 1'b0);   // -1 + -1
        issue(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

        // Hold: capture 2+2, then three disabled edges with new operands.
        issue(4'h2, 4'h2, 4'h4, 4'h4, 1'b0, 1'b0);
        drive(1'b0, 4'hA, 4'hA);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("hold_c_wrap", 32'(if0.c),     32'h4);
            chk("hold_c_sat",  32'(if1.c),     32'h4);
            chk("hold_carry",  32'(if0.carry), 32'h0);
            chk("hold_valid",  32'(if0.valid), 32'h0);
        end

        // Mid-run async reset: reach c=9, then assert reset between edges
        // while a new capture is pending on the inputs.
        issue(4'h4, 4'h5, 4'h9, 4'h9, 1'b0, 1'b1);
        drive(1'b1, 4'h1, 4'h1);
        #2 reset_L = 1'b0;
        #1 chk_cleared("async_reset");
        @(negedge clk);
        #1 chk_cleared("async_reset_edge");

        drive(1'b0, 4'h0, 4'h0);
        reset_L = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_c", 32'(if0.c), 32'h0);

        // Re-enable: sum appears one edge later.
        issue(4'h6, 4'h7, 4'hD, 4'hD, 1'b0, 1'b1);
        drive(1'b0, 4'h0, 4'h0);

        // Drain the scoreboard within a bounded number of cycles.
        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        #1;
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d results never presented, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
